// File: rtl/juice_tap.sv
// rtl/juice_tap.sv - juice counter step monitor with queued fruit events
// juice_tap ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   juice[2:0]   monitored wrapping counter
//   fruit_valid  event queue head valid
//   fruit_ready  consumer accepts head
//   fruit_seq    head event sequence number (0 when empty)
//   total        events counted since reset
//   err          sticky illegal-step fault
//   overflow     sticky dropped-event flag
// juice_tap_fifo ports:
//   push/push_data  write request, accepted when not full or when popping
//   out_ready/out_valid/out_data  head handshake
//   drop            push rejected because full with no pop

module juice_tap_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         drop
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             full, pop, wr_en;

  always_comb begin
    full      = (count_q == FULL_CNT);
    out_valid = (count_q != '0);
    pop       = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full queue can still accept.
    wr_en     = push && (!full || pop);
    drop      = push && full && !pop;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (wr_en && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !wr_en) begin
      count_d = count_q - 1'b1;
    end
  end

  // Head comes straight from storage registers; no path from push_data or out_ready.
  assign out_data = out_valid ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

module juice_tap #(
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       juice,
  output logic             fruit_valid,
  input  logic             fruit_ready,
  output logic [CNT_W-1:0] fruit_seq,
  output logic [CNT_W-1:0] total,
  output logic             err,
  output logic             overflow
);
  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       prev_q, prev_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic             err_q, err_d;
  logic             overflow_q, overflow_d;
  logic [2:0]       delta;
  logic             step_evt, step_bad;
  logic             fifo_drop;

  // Modulo-8 difference; a decrement lands in 2..7 and is treated as illegal.
  assign delta = juice - prev_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SYNC:  state_d = ST_TRACK;
      ST_TRACK: if (delta >= 3'd2) state_d = ST_FAULT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_SYNC;
    endcase
  end

  always_comb begin
    prev_d   = prev_q;
    step_evt = 1'b0;
    step_bad = 1'b0;
    case (state_q)
      ST_SYNC: begin
        prev_d = juice;
      end
      ST_TRACK: begin
        prev_d   = juice;
        step_evt = (delta == 3'd1);
        step_bad = (delta >= 3'd2);
      end
      default: begin
        prev_d = prev_q;
      end
    endcase
  end

  always_comb begin
    total_d    = step_evt ? total_q + 1'b1 : total_q;
    err_d      = err_q | step_bad;
    overflow_d = overflow_q | fifo_drop;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q     <= '0;
      total_q    <= '0;
      err_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      total_q    <= total_d;
      err_q      <= err_d;
      overflow_q <= overflow_d;
    end
  end

  // The event carries the pre-increment total as its sequence number.
  juice_tap_fifo #(
    .W     (CNT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (step_evt),
    .push_data (total_q),
    .out_ready (fruit_ready),
    .out_valid (fruit_valid),
    .out_data  (fruit_seq),
    .drop      (fifo_drop)
  );

  assign total    = total_q;
  assign err      = err_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_juice_tap.sv
// tb/tb_juice_tap.sv - directed vector bench for juice_tap
module tb_juice_tap;
  logic        clk;
  logic        rst;
  logic [2:0]  juice;
  logic        fruit_valid;
  logic        fruit_ready;
  logic [15:0] fruit_seq;
  logic [15:0] total;
  logic        err;
  logic        overflow;

  int nvec = 0;
  int nbad = 0;

  juice_tap #(.CNT_W(16), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .juice       (juice),
    .fruit_valid (fruit_valid),
    .fruit_ready (fruit_ready),
    .fruit_seq   (fruit_seq),
    .total       (total),
    .err         (err),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [2:0]  juice;
    logic        ready;
    logic        valid;
    logic [15:0] seq;
    logic [15:0] total;
    logic        err;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [2:0] j, input logic rd, input logic v,
                     input logic [15:0] s, input logic [15:0] t, input logic e, input logic o);
    vec_t x;
    x.rst = r; x.juice = j; x.ready = rd; x.valid = v;
    x.seq = s; x.total = t; x.err = e; x.ovf = o;
    vecs.push_back(x);
  endtask

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s vec %0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  // Drive inputs, take one edge, sample 1 time unit later and compare all outputs.
  task automatic apply(input int idx, input vec_t x);
    rst = x.rst; juice = x.juice; fruit_ready = x.ready;
    @(posedge clk);
    #1;
    nvec++;
    chk("fruit_valid", idx, {15'd0, fruit_valid}, {15'd0, x.valid});
    chk("fruit_seq",   idx, fruit_seq, x.seq);
    chk("total",       idx, total, x.total);
    chk("err",         idx, {15'd0, err}, {15'd0, x.err});
    chk("overflow",    idx, {15'd0, overflow}, {15'd0, x.ovf});
  endtask

  initial begin
    vec_t h;
    int waited;
    rst = 1'b0; juice = 3'd0; fruit_ready = 1'b0;

    // reset + idle hold at 5
    add(0,5,0, 0,0,0,0,0);
    for (int i = 0; i < 10; i++) add(1,5,0, 0,0,0,0,0);
    // increment with wrap, ready high
    add(1,5,1, 0,0,0,0,0);
    add(1,6,1, 1,0,1,0,0);
    add(1,7,1, 1,1,2,0,0);
    add(1,0,1, 1,2,3,0,0);
    add(1,1,1, 1,3,4,0,0);
    add(1,1,1, 0,0,4,0,0);
    // backpressure and overflow
    add(0,0,0, 0,0,0,0,0);
    add(1,0,0, 0,0,0,0,0);
    add(1,1,0, 1,0,1,0,0);
    add(1,2,0, 1,0,2,0,0);
    add(1,3,0, 1,0,3,0,0);
    add(1,4,0, 1,0,4,0,0);
    add(1,5,0, 1,0,5,0,1);
    add(1,6,0, 1,0,6,0,1);
    add(1,6,1, 1,1,6,0,1);
    add(1,6,1, 1,2,6,0,1);
    add(1,6,1, 1,3,6,0,1);
    add(1,6,1, 0,0,6,0,1);
    // full FIFO with simultaneous push and pop
    add(0,0,0, 0,0,0,0,0);
    add(1,0,0, 0,0,0,0,0);
    add(1,1,0, 1,0,1,0,0);
    add(1,2,0, 1,0,2,0,0);
    add(1,3,0, 1,0,3,0,0);
    add(1,4,0, 1,0,4,0,0);
    add(1,5,1, 1,1,5,0,0);
    add(1,5,1, 1,2,5,0,0);
    add(1,5,1, 1,3,5,0,0);
    add(1,5,1, 1,4,5,0,0);
    add(1,5,1, 0,0,5,0,0);
    // fault by jump 5 -> 7
    add(0,4,0, 0,0,0,0,0);
    add(1,4,0, 0,0,0,0,0);
    add(1,5,0, 1,0,1,0,0);
    add(1,7,0, 1,0,1,1,0);
    add(1,0,0, 1,0,1,1,0);
    add(1,1,0, 1,0,1,1,0);
    add(1,1,1, 0,0,1,1,0);
    add(1,2,1, 0,0,1,1,0);
    // fault by decrement 6 -> 5
    add(0,5,0, 0,0,0,0,0);
    add(1,5,0, 0,0,0,0,0);
    add(1,6,0, 1,0,1,0,0);
    add(1,5,0, 1,0,1,1,0);
    add(1,6,0, 1,0,1,1,0);
    add(1,6,1, 0,0,1,1,0);
    // reset mid-stream
    add(0,0,0, 0,0,0,0,0);
    add(1,0,0, 0,0,0,0,0);
    add(1,1,0, 1,0,1,0,0);
    add(1,2,0, 1,0,2,0,0);
    add(1,3,0, 1,0,3,0,0);
    add(0,3,0, 0,0,0,0,0);
    add(1,6,0, 0,0,0,0,0);
    add(1,7,0, 1,0,1,0,0);
    add(1,7,1, 0,0,1,0,0);

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // stalled head must hold while more events queue up and one overflows
    h = '{rst:0, juice:0, ready:0, valid:0, seq:0, total:0, err:0, ovf:0};
    apply(1000, h);
    h.rst = 1; apply(1001, h);
    h.juice = 1; h.valid = 1; h.total = 1; apply(1002, h);
    for (int k = 0; k < 5; k++) begin
      h.juice = 3'(k + 2);
      h.total = 16'(k + 2);
      h.ovf   = (k >= 3);
      apply(1010 + k, h);
    end

    // sustained throughput: one event per cycle with ready held high
    h = '{rst:0, juice:0, ready:1, valid:0, seq:0, total:0, err:0, ovf:0};
    apply(1100, h);
    h.rst = 1; apply(1101, h);
    for (int k = 0; k < 10; k++) begin
      h.juice = 3'((k + 1) % 8);
      h.valid = 1;
      h.seq   = 16'(k);
      h.total = 16'(k + 1);
      apply(1110 + k, h);
    end

    // queue must empty within a bounded number of cycles once steps stop
    waited = 0;
    while (fruit_valid && waited < 4) begin
      @(posedge clk);
      #1;
      waited++;
    end
    nvec++;
    if (fruit_valid !== 1'b0) begin
      nbad++;
      $display("FAIL drain_timeout: fruit_valid %0b after %0d cycles, required 0", fruit_valid, waited);
    end
    if (waited != 1) begin
      nbad++;
      $display("FAIL drain_latency: took %0d cycles, required 1", waited);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule

// File: doc/juice_tap.md
# juice_tap

Receive-side monitor for the 3-bit `juice` counter of the fruit-bowl stage. It watches the wrapping counter, recovers each single-step increment as a "fruit" event, and counts events in a wider running total. Events are queued in a small FIFO and handed to a downstream consumer over a valid/ready handshake. Illegal counter motion is flagged as a sticky fault.

## Interface
Parameters:
- `CNT_W`, 16, width of the running total and event sequence number.
- `FIFO_DEPTH`, 4, event queue depth; must be a power of 2 and at least 2.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-low: sampled low on a rising `clk` edge resets the block.
- `juice`  in  3  monitored counter; advances by 0 or 1 per cycle, wrapping modulo 8.
- `fruit_valid`  out  1  FIFO head holds an event.
- `fruit_ready`  in  1  consumer accepts the head entry when `fruit_valid` is also high.
- `fruit_seq`  out  CNT_W  sequence number of the head event; 0 when empty.
- `total`  out  CNT_W  events counted since reset, wrapping modulo 2^CNT_W.
- `err`  out  1  sticky fault: illegal `juice` step seen.
- `overflow`  out  1  sticky: at least one event was dropped because the FIFO was full.

## Operation
- Registered state: `prev` (3 bits), `total`, FSM state, FIFO storage, pointers and count, `err`, `overflow`.
- FSM states: SYNC, TRACK, FAULT. Reset enters SYNC.
- SYNC (one cycle):
  - `prev` <= `juice`.
  - Go to TRACK. No event is generated and no error check is made.
- TRACK: each cycle compute `delta = (juice - prev) mod 8`, 3-bit wrapping subtract, then `prev` <= `juice`.
  - `delta == 0`: no action.
  - `delta == 1`:
    - Event with `seq = total`, taken before the increment.
    - `total` <= `total + 1`.
    - Push `seq` into the FIFO.
    - A wrap from 7 to 0 is a legal increment.
  - `delta >= 2`, which includes any decrement:
    - `err` <= 1 and go to FAULT.
    - No event is generated.
    - `total` is unchanged.
- FAULT:
  - Terminal until reset.
  - `juice` is ignored and `total` is frozen.
  - The FIFO keeps draining normally.
- FIFO:
  - Pop occurs when `fruit_valid && fruit_ready`.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full: the pop frees the slot, the push is accepted, and `overflow` is not set.
  - Push to a full FIFO with no pop: the event is dropped and `overflow` <= 1. `total` still increments.
  - No bypass: a pushed entry is visible only from the next cycle.
- `fruit_seq` shows the FIFO head while `fruit_valid` is high, and 0 otherwise.

## Timing
- Reset values (the cycle after `rst` is sampled low):
  - `fruit_valid` = 0, `fruit_seq` = 0, `total` = 0, `err` = 0, `overflow` = 0.
  - FIFO empty, FSM in SYNC.
- Reset mid-operation discards all queued events and returns the FSM to SYNC.
- Event latency: when `juice` sampled at edge k is `prev`+1:
  - the FIFO is written at edge k;
  - `total` updates at edge k;
  - `fruit_valid` is high from edge k onward if the FIFO was empty.
- Fault latency: an illegal step sampled at edge k sets `err` at edge k. `err` and `overflow` never clear except by reset.
- Handshake throughput: one event per cycle sustained when `fruit_ready` is held high.
- Handshake stability: `fruit_valid` and `fruit_seq` are register outputs. While `fruit_valid` is high and `fruit_ready` is low, `fruit_seq` holds stable.
- Combinational paths: none from `fruit_ready` to `fruit_valid`.

## Test plan
- Idle hold:
  - Stimulus: reset, release, hold `juice`=5 for 10 cycles.
  - Required: `fruit_valid`=0, `total`=0, `err`=0, `overflow`=0 throughout.
- Increment with wrap:
  - Stimulus: `fruit_ready`=1; `juice` sequence 5,6,7,0,1, one value per cycle.
  - Required: four events with `fruit_seq` 0,1,2,3, each `fruit_valid` one cycle after the step; final `total`=4; `err`=0.
- Backpressure and overflow:
  - Stimulus: `FIFO_DEPTH`=4, `fruit_ready`=0, six single-step increments; then `fruit_ready`=1.
  - Required: `overflow` rises on the 5th increment; final `total`=6; draining then yields `fruit_seq` 0,1,2,3 and `fruit_valid` drops.
- Full-FIFO push and pop in the same cycle:
  - Stimulus: fill 4 entries (seq 0..3), then assert `fruit_ready` in the same cycle as the next increment.
  - Required: seq 0 is popped, seq 4 is accepted, `overflow` stays 0.
- Fault:
  - Stimulus: `juice` jumps 5 to 7.
  - Required: `err`=1 at that edge; `total` frozen; later single steps are ignored; queued entries still drain. Repeat with a 6 to 5 decrement: same response.
- Reset mid-stream:
  - Stimulus: 3 entries queued and `total`=3; drive `rst` low for one edge.
  - Required: all outputs 0 and FIFO empty. After release, the first `juice` value is captured with no event, and the next step yields `fruit_seq`=0.
